// File: rtl/mod3_pkg.sv
// Shared definitions for the multiple-of-three serializer slice: state codes,
// default word width and the detector's remainder step.
package mod3_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CLEAR   = 3'd1,
        SHIFT   = 3'd2,
        CAPTURE = 3'd3,
        DONE    = 3'd4
    } state_t;

    // Next remainder after appending one bit: (2r + b) mod 3.
    function automatic logic [1:0] mod3_step(input logic [1:0] r, input logic b);
        logic [1:0] nxt;
        case ({r, b})
            3'b00_0: nxt = 2'd0;
            3'b00_1: nxt = 2'd1;
            3'b01_0: nxt = 2'd2;
            3'b01_1: nxt = 2'd0;
            3'b10_0: nxt = 2'd1;
            3'b10_1: nxt = 2'd2;
            default: nxt = 2'd0;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/mod3_word_serializer_if.sv
// Word-in / result-out valid-ready handshakes of the serializer.
interface mod3_word_serializer_if
    import mod3_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_data;
    logic             res_mul3;

    modport master (
        output in_valid, in_data, res_ready,
        input  in_ready, res_valid, res_data, res_mul3
    );

    modport slave (
        input  in_valid, in_data, res_ready,
        output in_ready, res_valid, res_data, res_mul3
    );
endinterface

// File: rtl/mod3_detector.sv
// Serial multiple-of-three detector: registers whether the MSB-first bit stream
// seen since the last clear is divisible by three.
module mod3_detector
    import mod3_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic out
);
    logic [1:0] r;
    logic [1:0] r_n;

    assign r_n = mod3_step(r, in);

    always_ff @(posedge clk) begin
        if (rst) begin
            r   <= '0;
            out <= 1'b0;
        end else begin
            r   <= r_n;
            out <= (r_n == 2'd0);
        end
    end
endmodule

// File: rtl/piso_shift_reg.sv
// Parallel-load, shift-left (zero fill) register with an MSB tap.
module piso_shift_reg
    import mod3_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    output logic             msb
);
    logic [WIDTH-1:0] sr;

    always_ff @(posedge clk) begin
        if (rst)        sr <= '0;
        else if (load)  sr <= din;
        else if (shift) sr <= sr << 1;
    end

    assign msb = sr[WIDTH-1];
endmodule

// File: rtl/mod3_word_serializer.sv
// Feeds a parallel word MSB-first into the serial mod-3 detector and returns the
// word together with the detector's verdict.
module mod3_word_serializer
    import mod3_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    mod3_word_serializer_if.slave  bus,
    output logic                   ser_out,
    output logic                   ser_clr,
    input  logic                   det_in
);
    localparam int unsigned   CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    state_t           state_n;
    logic [CW-1:0]    cnt;
    logic             last_bit;
    logic             load;
    logic             shift;
    logic             msb;
    logic             in_ready_q;
    logic             res_valid_q;
    logic             res_mul3_q;
    logic [WIDTH-1:0] res_data_q;

    piso_shift_reg #(.WIDTH(WIDTH)) u_sr (
        .clk   (clk),
        .rst   (rst),
        .load  (load),
        .shift (shift),
        .din   (bus.in_data),
        .msb   (msb)
    );

    assign last_bit = (cnt == LAST);

    // The register is shifted on the CLEAR exit edge as well, so that ser_out can
    // be registered from the MSB tap one bit ahead of the shift.
    always_comb begin
        state_n = state;
        load    = 1'b0;
        shift   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    state_n = CLEAR;
                    load    = 1'b1;
                end
            end
            CLEAR: begin
                state_n = SHIFT;
                shift   = 1'b1;
            end
            SHIFT: begin
                if (last_bit) state_n = CAPTURE;
                else          shift   = 1'b1;
            end
            CAPTURE: state_n = DONE;
            DONE: begin
                if (bus.res_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            in_ready_q  <= 1'b1;
            res_valid_q <= 1'b0;
            res_mul3_q  <= 1'b0;
            res_data_q  <= '0;
            ser_out     <= 1'b0;
            ser_clr     <= 1'b1;
        end else begin
            state       <= state_n;
            in_ready_q  <= (state_n == IDLE);
            res_valid_q <= (state_n == DONE);
            ser_clr     <= (state_n == CLEAR);
            ser_out     <= (state_n == SHIFT) ? msb : 1'b0;
            if (load) begin
                res_data_q <= bus.in_data;
                cnt        <= '0;
            end else if (state == SHIFT) begin
                cnt <= cnt + CW'(1);
            end
            if (state == CAPTURE) res_mul3_q <= det_in;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;
    assign bus.res_mul3  = res_mul3_q;
endmodule

// File: tb/tb_mod3_word_serializer.sv
// Scoreboard bench for mod3_word_serializer (WIDTH=8 and WIDTH=1) driving the serial detector.
module tb_mod3_word_serializer;
    import mod3_pkg::*;

    typedef struct packed {
        logic [7:0] d;
        logic       m;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic ser_out8, ser_clr8, det8;
    logic ser_out1, ser_clr1, det1;
    logic rr_rand, rr_fixed, rr_rnd, rr1;

    int unsigned cyc   = 0;
    int unsigned npass = 0;
    int unsigned nchk  = 0;
    exp_t q8[$];
    exp_t q1[$];
    exp_t e8, e1;

    mod3_word_serializer_if #(.WIDTH(8)) b8 ();
    mod3_word_serializer_if #(.WIDTH(1)) b1 ();

    mod3_word_serializer #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .bus(b8), .ser_out(ser_out8), .ser_clr(ser_clr8), .det_in(det8)
    );
    mod3_detector det_u8 (.clk(clk), .rst(ser_clr8), .in(ser_out8), .out(det8));

    mod3_word_serializer #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .bus(b1), .ser_out(ser_out1), .ser_clr(ser_clr1), .det_in(det1)
    );
    mod3_detector det_u1 (.clk(clk), .rst(ser_clr1), .in(ser_out1), .out(det1));

    assign b8.res_ready = rr_rand ? rr_rnd : rr_fixed;
    assign b1.res_ready = rr1;

    always @(posedge clk) begin
        cyc    <= cyc + 1;
        rr_rnd <= 1'($urandom_range(0, 1));
    end

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endfunction

    // Monitors: pop expected results whenever a result handshake is presented.
    always @(negedge clk) begin
        if (!rst && b8.res_valid && b8.res_ready) begin
            check("w8_sb_nonempty", 32'(q8.size() != 0), 1);
            if (q8.size() != 0) begin
                e8 = q8.pop_front();
                check("w8_res_data", b8.res_data, e8.d);
                check("w8_res_mul3", b8.res_mul3, e8.m);
            end
        end
        if (!rst && b1.res_valid && b1.res_ready) begin
            check("w1_sb_nonempty", 32'(q1.size() != 0), 1);
            if (q1.size() != 0) begin
                e1 = q1.pop_front();
                check("w1_res_data", b1.res_data, e1.d[0]);
                check("w1_res_mul3", b1.res_mul3, e1.m);
            end
        end
    end

    task automatic send8(input logic [7:0] d, input bit push, output int unsigned acc);
        bit   ok;
        exp_t e;
        ok = 1'b0;
        b8.in_data  = d;
        b8.in_valid = 1'b1;
        for (int i = 0; i < 64 && !ok; i++) begin
            @(negedge clk);
            ok = b8.in_ready;
            @(posedge clk);
        end
        #1;
        b8.in_valid = 1'b0;
        acc = cyc;
        check("w8_accept", 32'(ok), 1);
        if (ok && push) begin
            e.d = d;
            e.m = ((d % 3) == 0);
            q8.push_back(e);
        end
    endtask

    task automatic send1(input logic d);
        bit   ok;
        exp_t e;
        ok = 1'b0;
        b1.in_data  = d;
        b1.in_valid = 1'b1;
        for (int i = 0; i < 32 && !ok; i++) begin
            @(negedge clk);
            ok = b1.in_ready;
            @(posedge clk);
        end
        #1;
        b1.in_valid = 1'b0;
        check("w1_accept", 32'(ok), 1);
        if (ok) begin
            e.d = {7'd0, d};
            e.m = (d == 1'b0);
            q1.push_back(e);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        int unsigned t0, t1, t2;
        logic [7:0]  a5;
        logic [7:0]  vals [256];
        logic [7:0]  tmp;
        int unsigned j;
        bit          seen;

        rst = 1'b1;
        rr_rand = 1'b0; rr_fixed = 1'b1; rr1 = 1'b1;
        b8.in_valid = 1'b0; b8.in_data = '0;
        b1.in_valid = 1'b0; b1.in_data = '0;

        // Reset values while rst is sampled high.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ser_clr", ser_clr8, 1);
        check("rst_in_ready", b8.in_ready, 1);
        check("rst_res_valid", b8.res_valid, 0);
        check("rst_res_data", b8.res_data, 0);
        check("rst_res_mul3", b8.res_mul3, 0);
        check("rst_ser_out", ser_out8, 0);
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); @(negedge clk);
        check("post_rst_ser_clr", ser_clr8, 0);
        check("post_rst_in_ready", b8.in_ready, 1);
        @(posedge clk); #1;

        // Ordering and latency for 0xA5.
        a5 = 8'hA5;
        send8(a5, 1'b1, t0);
        @(negedge clk);
        check("lat_c1_ser_clr", ser_clr8, 1);
        check("lat_c1_ser_out", ser_out8, 0);
        for (int k = 2; k <= 9; k++) begin
            @(negedge clk);
            check("lat_ser_out_bit", ser_out8, a5[9 - k]);
            check("lat_ser_clr_low", ser_clr8, 0);
        end
        @(negedge clk);
        check("lat_c10_res_valid", b8.res_valid, 0);
        check("lat_c10_ser_out", ser_out8, 0);
        @(negedge clk);
        check("lat_c11_res_valid", b8.res_valid, 1);
        @(posedge clk); #1;

        // Backpressure in DONE.
        rr_fixed = 1'b0;
        send8(8'h07, 1'b1, t0);
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            seen = b8.res_valid;
        end
        check("bp_res_valid_seen", 32'(seen), 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_res_valid", b8.res_valid, 1);
            check("bp_res_data", b8.res_data, 8'h07);
            check("bp_res_mul3", b8.res_mul3, 0);
            check("bp_in_ready", b8.in_ready, 0);
        end
        @(posedge clk); #1 rr_fixed = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("bp_idle_in_ready", b8.in_ready, 1);
        check("bp_idle_res_valid", b8.res_valid, 0);
        @(posedge clk); #1;

        // Busy input held during SHIFT.
        send8(8'h0C, 1'b1, t1);
        repeat (3) @(posedge clk);
        #1;
        check("busy_in_ready", b8.in_ready, 0);
        send8(8'h06, 1'b1, t2);
        check("busy_period", t2 - t1, 12);

        // Reset mid-shift of 0x55 (word aborted, not expected).
        send8(8'h55, 1'b0, t0);
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); @(negedge clk);
        check("mid_rst_in_ready", b8.in_ready, 1);
        check("mid_rst_res_valid", b8.res_valid, 0);
        check("mid_rst_ser_clr", ser_clr8, 1);
        check("mid_rst_ser_out", ser_out8, 0);
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); @(posedge clk); @(negedge clk);
        check("mid_rst_clr_done", ser_clr8, 0);
        @(posedge clk); #1;
        send8(8'h01, 1'b1, t0);

        // Named verdicts, then a shuffled sweep of every value with random backpressure.
        rr_rand = 1'b1;
        send8(8'h00, 1'b1, t0);
        send8(8'h03, 1'b1, t0);
        send8(8'h07, 1'b1, t0);
        send8(8'h80, 1'b1, t0);
        send8(8'hFF, 1'b1, t0);
        for (int i = 0; i < 256; i++) vals[i] = 8'(i);
        for (int i = 255; i > 0; i--) begin
            j = $urandom_range(0, i);
            tmp = vals[i]; vals[i] = vals[j]; vals[j] = tmp;
        end
        for (int i = 0; i < 256; i++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            send8(vals[i], 1'b1, t0);
        end
        rr_rand = 1'b0; rr_fixed = 1'b1;
        for (int i = 0; i < 200 && q8.size() != 0; i++) @(posedge clk);
        #1;
        check("w8_drain", q8.size(), 0);

        // WIDTH=1 instance.
        send1(1'b1);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            check("w1_lat_res_valid", b1.res_valid, 32'(k == 4));
        end
        @(posedge clk); #1;
        send1(1'b0);
        for (int i = 0; i < 20; i++) send1(1'($urandom_range(0, 1)));
        for (int i = 0; i < 50 && q1.size() != 0; i++) @(posedge clk);
        #1;
        check("w1_drain", q1.size(), 0);

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end
endmodule

// File: doc/mod3_word_serializer.md
# mod3_word_serializer

Upstream feeder for the serial multiple-of-three detector in the two's-complement/FSM group. Accepts a parallel WIDTH-bit word over a valid/ready handshake. Clears the detector, then shifts the word into it MSB-first, one bit per clock. Samples the detector's registered verdict and returns it with the original word over a second valid/ready handshake.

## Interface
- WIDTH, default 8: word width in bits; legal range ≥ 1.
- clk  in  1: single clock; all logic on posedge.
- rst  in  1: synchronous, active-high reset.
- in_valid  in  1: input word offered.
- in_ready  out  1: block can accept a word.
- in_data  in  WIDTH: word to test (unsigned).
- ser_out  out  1: serial bit to the detector's `in`.
- ser_clr  out  1: clear pulse to the detector's `rst`.
- det_in  in  1: detector's `out`.
- res_valid  out  1: result available.
- res_ready  in  1: consumer takes result.
- res_data  out  WIDTH: copy of the accepted word.
- res_mul3  out  1: 1 if res_data mod 3 == 0.

## Operation
FSM states and transitions:
- IDLE
  - in_ready=1.
  - in_valid=1 loads shift register and res_data from in_data, clears bit counter, moves to CLEAR.
- CLEAR
  - One cycle, ser_clr=1, ser_out=0.
  - Always moves to SHIFT.
- SHIFT
  - ser_out = shift_reg[WIDTH-1].
  - Each cycle: shift left by one (zero fill), counter +1.
  - After WIDTH cycles moves to CAPTURE.
- CAPTURE
  - One cycle, ser_out=0.
  - At the closing edge, res_mul3 <= det_in; moves to DONE.
- DONE
  - res_valid=1; res_data and res_mul3 held stable.
  - res_ready=1 moves to IDLE.

Further rules:
- All outputs registered.
- ser_out=0 outside SHIFT; ser_clr=0 outside CLEAR and reset.
- in_ready=0 in every state except IDLE. in_valid in other states is ignored; the word is not lost, the producer holds it.
- Counter width is $clog2(WIDTH+1). Terminal count is WIDTH-1 on the last SHIFT cycle.
- The detector computes remainder r' = (2r + bit) mod 3 and registers (r' == 0). The verdict after the last bit is valid in the CAPTURE cycle.
- The all-zeros word yields res_mul3=1.

Reset values:
- State IDLE.
- in_ready=1 from the first cycle after rst falls.
- ser_clr=1 while rst is sampled high, so the detector is cleared alongside this block.
- ser_out=0, res_valid=0, res_mul3=0, res_data=0, shift register and counter 0.

## Timing
Cycle k means the k-th clock cycle after the accept edge (in_valid & in_ready):
- Cycle 1: CLEAR, ser_clr=1.
- Cycles 2 to WIDTH+1: bits MSB down to LSB on ser_out. The detector samples each bit at the end of its cycle.
- Cycle WIDTH+2: CAPTURE.
- Cycle WIDTH+3 onward: res_valid=1. For WIDTH=8, res_valid rises in cycle 11.

Handshake and throughput:
- The result handshake completes on the edge where res_valid & res_ready. The block is in IDLE the next cycle.
- Back-to-back minimum period is WIDTH+4 cycles.

Reset mid-operation:
- rst in any state aborts the word, drops res_valid and returns to IDLE.
- The detector is re-cleared via ser_clr.

## Structure
- Shared package mod3_pkg holds:
  - State encoding localparams: IDLE=3'd0, CLEAR=3'd1, SHIFT=3'd2, CAPTURE=3'd3, DONE=3'd4.
  - Default WIDTH.
- Unused state codes decode to IDLE.
- One natural sub-module: piso_shift_reg (parallel load, shift-left, MSB tap, WIDTH parameter).
- FSM, counter and result registers live in the top.
- Bench instantiates this block with the detector, wiring ser_out→in, ser_clr→rst, out→det_in.

## Test plan
- Ordering/latency, WIDTH=8: accept in_data=0xA5 → ser_clr=1 in cycle 1; ser_out = 1,0,1,0,0,1,0,1 in cycles 2–9; res_valid in cycle 11 with res_data=0xA5, res_mul3=1 (165 = 3·55).
- Verdicts: 0x00→1, 0x03→1, 0x07→0, 0x80→0, 0xFF→1. Checked against a data mod 3 model over all 256 values.
- Backpressure: hold res_ready=0 for 5 cycles in DONE → res_valid, res_data and res_mul3 stable, in_ready=0. Assert res_ready → IDLE next cycle.
- Busy input:
  - in_valid held high during SHIFT with a second word 0x06 → not accepted until IDLE.
  - Then processed with res_mul3=1.
  - Period from first accept to second accept is 12 cycles when res_ready=1.
- Reset mid-shift:
  - Assert rst in cycle 5 of word 0x55 → next cycle IDLE, res_valid=0, ser_clr=1 while rst high.
  - Following word 0x01 → res_mul3=0.
- WIDTH=1 instance: 1 → res_mul3=0, 0 → res_mul3=1; res_valid in cycle 4.
